// File: rtl/lvds_rx_pkg.sv
// lvds_rx_pkg: shared encodings and constants for the LVDS RX arbiter slice
package lvds_rx_pkg;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_STALL = 2'b11
    } state_e;
    localparam logic CH_09 = 1'b0;
    localparam logic CH_24 = 1'b1;
    localparam logic [1:0] BUF_DEPTH = 2'd2;
endpackage

// File: rtl/lvds_rx_skid2.sv
// lvds_rx_skid2: 2-entry holding buffer; a full buffer still accepts when popped the same cycle
module lvds_rx_skid2
    import lvds_rx_pkg::*;
(
    input  logic        i_ddr_clk,
    input  logic        i_rst_b,
    input  logic        push_i,
    input  logic        pop_i,
    input  logic        flush_i,
    input  logic [31:0] data_i,
    output logic        accept_o,
    output logic [31:0] data_o,
    output logic [1:0]  count_o
);
    logic [31:0] head_q, head_d, tail_q, tail_d;
    logic [1:0]  count_q, count_d, level;
    logic        wr;
    assign accept_o = push_i && (count_q != BUF_DEPTH || pop_i);
    assign wr       = accept_o;
    assign data_o   = head_q;
    assign count_o  = count_q;
    always_comb begin
        level   = count_q - {1'b0, pop_i};
        head_d  = (wr && level == 2'd0) ? data_i : pop_i ? tail_q : head_q;
        tail_d  = (wr && level == 2'd1) ? data_i : tail_q;
        count_d = flush_i ? 2'd0 : level + {1'b0, wr};
    end
    always_ff @(posedge i_ddr_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/lvds_rx_arbiter.sv
// lvds_rx_arbiter: merges ch0/ch1 LVDS sample streams onto the shared RX FIFO write port
// Define LVDS_RX_ARB_DROP_CNT_EN to build the per-channel saturating drop counters.
module lvds_rx_arbiter
    import lvds_rx_pkg::*;
#(
    parameter int DROP_CNT_W = 16
) (
    input  logic                  i_ddr_clk,
    input  logic                  i_rst_b,
    input  logic [1:0]            i_ch_en,
    input  logic                  i_rr_en,
    input  logic                  i_cnt_clr,
    input  logic                  i_ch0_push,
    input  logic [31:0]           i_ch0_data,
    input  logic                  i_ch1_push,
    input  logic [31:0]           i_ch1_data,
    input  logic                  i_fifo_full,
    output logic                  o_fifo_push,
    output logic [31:0]           o_fifo_data,
    output logic [DROP_CNT_W-1:0] o_ch0_drop_cnt,
    output logic [DROP_CNT_W-1:0] o_ch1_drop_cnt,
    output logic [1:0]            o_debug_state
);
    logic [1:0]  push_v, accept, req, gnt, cnt0, cnt1;
    logic [31:0] head0, head1, data_q, data_d;
    logic        push_q, push_d, last_q, last_d;
    state_e      state_q, state_d;
    logic        unused_bits;
    assign push_v = i_ch_en & {i_ch1_push, i_ch0_push};
    assign req    = i_ch_en & {|cnt1, |cnt0};
    assign unused_bits = head0[0] ^ head1[0];
    lvds_rx_skid2 u_ch0 (
        .i_ddr_clk(i_ddr_clk), .i_rst_b(i_rst_b), .push_i(push_v[0]), .pop_i(gnt[0]),
        .flush_i(!i_ch_en[0]), .data_i(i_ch0_data), .accept_o(accept[0]), .data_o(head0), .count_o(cnt0)
    );
    lvds_rx_skid2 u_ch1 (
        .i_ddr_clk(i_ddr_clk), .i_rst_b(i_rst_b), .push_i(push_v[1]), .pop_i(gnt[1]),
        .flush_i(!i_ch_en[1]), .data_i(i_ch1_data), .accept_o(accept[1]), .data_o(head1), .count_o(cnt1)
    );
    // ch0 loses a round-robin tie only when it was the last one served
    always_comb begin
        gnt[0]  = !i_fifo_full && req[0] && (!req[1] || !i_rr_en || last_q == CH_24);
        gnt[1]  = !i_fifo_full && req[1] && !gnt[0];
        push_d  = |gnt;
        last_d  = gnt[0] ? CH_09 : gnt[1] ? CH_24 : last_q;
        data_d  = gnt[0] ? {head0[31:1], CH_09} : gnt[1] ? {head1[31:1], CH_24} : data_q;
        state_d = ~|i_ch_en ? ST_IDLE : (i_fifo_full && |req) ? ST_STALL : ST_RUN;
    end
    always_ff @(posedge i_ddr_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            push_q  <= 1'b0;
            data_q  <= '0;
            last_q  <= CH_24;
            state_q <= ST_IDLE;
        end else begin
            push_q  <= push_d;
            data_q  <= data_d;
            last_q  <= last_d;
            state_q <= state_d;
        end
    end
    assign o_fifo_push   = push_q;
    assign o_fifo_data   = data_q;
    assign o_debug_state = state_q;
`ifdef LVDS_RX_ARB_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] drop0_q, drop0_d, drop1_q, drop1_d;
    logic [1:0]            drop;
    assign drop = push_v & ~accept;
    always_comb begin
        drop0_d = i_cnt_clr ? '0 : (drop[0] && ~&drop0_q) ? drop0_q + DROP_CNT_W'(1) : drop0_q;
        drop1_d = i_cnt_clr ? '0 : (drop[1] && ~&drop1_q) ? drop1_q + DROP_CNT_W'(1) : drop1_q;
    end
    always_ff @(posedge i_ddr_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            drop0_q <= '0;
            drop1_q <= '0;
        end else begin
            drop0_q <= drop0_d;
            drop1_q <= drop1_d;
        end
    end
    assign o_ch0_drop_cnt = drop0_q;
    assign o_ch1_drop_cnt = drop1_q;
`else
    logic unused_cfg;
    assign unused_cfg     = ^{i_cnt_clr, accept};
    assign o_ch0_drop_cnt = '0;
    assign o_ch1_drop_cnt = '0;
`endif
endmodule

// File: tb/tb_lvds_rx_arbiter.sv
// tb_lvds_rx_arbiter: queue-based reference model, per-cycle compare, directed plus random stimulus
module tb_lvds_rx_arbiter;
`ifdef LVDS_RX_ARB_DROP_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif
    logic        clk = 1'b0, rst_b = 1'b0;
    logic [1:0]  en = 2'b00;
    logic        rr = 1'b0, clr = 1'b0, p0 = 1'b0, p1 = 1'b0, full = 1'b0;
    logic [31:0] d0 = '0, d1 = '0;
    logic        o_push;
    logic [31:0] o_data;
    logic [15:0] o_drop0, o_drop1;
    logic [1:0]  o_state;
    int          n_tests = 0, n_fail = 0;

    logic [31:0] q0[$], q1[$];
    logic        m_last, m_push, r0, r1, w;
    logic [31:0] m_data, pd;
    int          m_d0, m_d1;
    logic [1:0]  m_state;

    always #5 clk = ~clk;

    lvds_rx_arbiter #(.DROP_CNT_W(16)) dut (
        .i_ddr_clk(clk), .i_rst_b(rst_b), .i_ch_en(en), .i_rr_en(rr), .i_cnt_clr(clr),
        .i_ch0_push(p0), .i_ch0_data(d0), .i_ch1_push(p1), .i_ch1_data(d1), .i_fifo_full(full),
        .o_fifo_push(o_push), .o_fifo_data(o_data), .o_ch0_drop_cnt(o_drop0),
        .o_ch1_drop_cnt(o_drop1), .o_debug_state(o_state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    // Reference model: each edge, serve one enabled non-empty queue, then enqueue arrivals
    initial forever begin
        @(posedge clk or negedge rst_b);
        if (!rst_b) begin
            q0.delete(); q1.delete();
            m_last = 1'b1; m_push = 1'b0; m_data = '0; m_d0 = 0; m_d1 = 0; m_state = 2'b00;
        end else begin
            r0 = en[0] && q0.size() > 0;
            r1 = en[1] && q1.size() > 0;
            m_state = (en == 2'b00) ? 2'b00 : (full && (r0 || r1)) ? 2'b11 : 2'b01;
            if (!full && (r0 || r1)) begin
                w = (r0 && r1) ? (rr ? !m_last : 1'b0) : !r0;
                pd = w ? q1.pop_front() : q0.pop_front();
                m_data = {pd[31:1], w};
                m_push = 1'b1;
                m_last = w;
            end else m_push = 1'b0;
            if (!en[0]) q0.delete();
            else if (p0) begin
                if (q0.size() < 2) q0.push_back(d0);
                else if (m_d0 < 65535) m_d0++;
            end
            if (!en[1]) q1.delete();
            else if (p1) begin
                if (q1.size() < 2) q1.push_back(d1);
                else if (m_d1 < 65535) m_d1++;
            end
            if (clr) begin m_d0 = 0; m_d1 = 0; end
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst_b) begin
            check("push", {31'b0, o_push}, {31'b0, m_push});
            check("data", o_data, m_data);
            check("drop0", {16'b0, o_drop0}, CNT_EN ? m_d0 : 0);
            check("drop1", {16'b0, o_drop1}, CNT_EN ? m_d1 : 0);
            check("state", {30'b0, o_state}, {30'b0, m_state});
        end
    end

    initial begin
        tick(3);
        check("rst_push", {31'b0, o_push}, 0);
        check("rst_data", o_data, 0);
        check("rst_state", {30'b0, o_state}, 0);
        check("rst_drop0", {16'b0, o_drop0}, 0);
        rst_b = 1'b1;
        tick(2);
        // single ch0 sample: two edges from push to strobe
        en = 2'b01; p0 = 1'b1; d0 = 32'hAAAA5554;
        tick(); p0 = 1'b0;
        check("t1_lat0", {31'b0, o_push}, 0);
        tick();
        check("t1_push", {31'b0, o_push}, 1);
        check("t1_data", o_data, 32'hAAAA5554);
        tick(3);
        // round-robin with alternating-cycle pushes on both channels
        en = 2'b11; rr = 1'b1;
        for (int i = 0; i < 16; i++) begin
            p0 = i[0] == 1'b0; p1 = p0;
            d0 = $urandom; d1 = $urandom;
            tick();
        end
        p0 = 1'b0; p1 = 1'b0;
        tick(4);
        // fixed priority: both buffers filled while full, then drained
        rr = 1'b0; full = 1'b1;
        p0 = 1'b1; p1 = 1'b1; d0 = 32'h11110000; d1 = 32'h33330004;
        tick();
        d0 = 32'h22220002; d1 = 32'h44440006;
        tick();
        p0 = 1'b0; p1 = 1'b0; full = 1'b0;
        tick(); check("t3_w0", o_data, 32'h11110000);
        tick(); check("t3_w1", o_data, 32'h22220002);
        tick(); check("t3_w2", o_data, 32'h33330005);
        tick(); check("t3_w3", o_data, 32'h44440007);
        tick(); check("t3_idle", {31'b0, o_push}, 0);
        // stall: 6 pushes into a 2-deep buffer while full
        clr = 1'b1; tick(); clr = 1'b0;
        en = 2'b01; full = 1'b1;
        for (int i = 0; i < 6; i++) begin
            p0 = 1'b1; d0 = $urandom; tick();
        end
        p0 = 1'b0;
        check("t4_state", {30'b0, o_state}, 32'h3);
        check("t4_nopush", {31'b0, o_push}, 0);
        check("t4_drop0", {16'b0, o_drop0}, CNT_EN ? 4 : 0);
        full = 1'b0;
        tick(); check("t4_out0", {31'b0, o_push}, 1);
        tick(); check("t4_out1", {31'b0, o_push}, 1);
        tick(); check("t4_out2", {31'b0, o_push}, 0);
        // disable flushes pending entries
        full = 1'b1;
        for (int i = 0; i < 2; i++) begin
            p0 = 1'b1; d0 = $urandom; tick();
        end
        p0 = 1'b0; en = 2'b00; full = 1'b0;
        tick();
        check("t5_state", {30'b0, o_state}, 0);
        check("t5_push", {31'b0, o_push}, 0);
        en = 2'b01;
        tick(3);
        check("t5_flushed", {31'b0, o_push}, 0);
        // saturation and clear-vs-increment priority
        clr = 1'b1; tick(); clr = 1'b0;
        en = 2'b11; full = 1'b1; p0 = 1'b1;
        for (int i = 0; i < 65540; i++) begin
            d0 = i; tick();
        end
        check("t6_sat", {16'b0, o_drop0}, CNT_EN ? 32'hFFFF : 0);
        clr = 1'b1; tick();
        check("t6_clr", {16'b0, o_drop0}, 0);
        clr = 1'b0; p0 = 1'b0; full = 1'b0;
        tick(4);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            en   = ($urandom_range(0, 31) == 0) ? 2'($urandom) : 2'b11;
            rr   = ($urandom_range(0, 99) == 0) ? ~rr : rr;
            full = $urandom_range(0, 3) == 0;
            clr  = $urandom_range(0, 63) == 0;
            p0   = $urandom_range(0, 2) == 0;
            p1   = $urandom_range(0, 2) == 0;
            d0   = $urandom; d1 = $urandom;
            tick();
        end
        // asynchronous reset in the middle of traffic
        rst_b = 1'b0;
        #1;
        check("mid_rst_push", {31'b0, o_push}, 0);
        check("mid_rst_data", o_data, 0);
        check("mid_rst_state", {30'b0, o_state}, 0);
        tick(2);
        rst_b = 1'b1;
        for (int i = 0; i < 500; i++) begin
            en = 2'b11; rr = 1'b1;
            full = $urandom_range(0, 4) == 0;
            p0 = $urandom_range(0, 1) == 0; p1 = $urandom_range(0, 1) == 0;
            d0 = $urandom; d1 = $urandom; clr = 1'b0;
            tick();
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
